// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the seven-segment display path.
//   seg_t      : 7-bit active-low segment vector, bit 6 = a ... bit 0 = g
//   SEG_OFF    : all segments dark
//   HEX_SEG    : hex nibble -> segment pattern table (0..9, A, b, C, d, E, F)
//   hex_to_seg : table lookup used by the decoder
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  localparam seg_t HEX_SEG [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex nibble to active-low seven-segment pattern.
//   nibble : input  [3:0] hex digit
//   seg    : output [6:0] active-low segments, bit 6 = a ... bit 0 = g
// -----------------------------------------------------------------------------
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// A prescaler divides the clock into digit slots of REFRESH_DIV cycles; the
// first BLANK_CYCLES of every slot keep all anodes off to avoid ghosting.
// Display data is captured atomically into shadow registers on load.
//   clock     : system clock, rising edge
//   reset     : synchronous, active-high
//   load      : capture strobe for value / dp_in / blank_in
//   value     : 4*NUM_DIGITS hex nibbles, value[3:0] is digit 0 (rightmost)
//   dp_in     : per-digit decimal point enable, 1 = lit
//   blank_in  : per-digit blanking, 1 = dark for the whole slot
//   anode     : active-low digit enables, anode[0] is the rightmost digit
//   cathode   : active-low segments, bit 6 = a ... bit 0 = g
//   dp        : active-low decimal point
//   slot_tick : one-cycle pulse on the first cycle of every digit slot
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   anode,
  output seg_t                    cathode,
  output logic                    dp,
  output logic                    slot_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pcnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   blank_q;

  logic [3:0]              nibble;
  seg_t                    digit_seg;
  logic                    in_blank;
  logic                    dark;
  logic [NUM_DIGITS-1:0]   anode_sel;

  // Only the active digit's nibble is decoded; one decoder serves all digits.
  assign nibble = value_q[{idx, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (digit_seg)
  );

  // With no anti-ghost window the comparison would be against zero and
  // always false, so it is removed outright.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (pcnt < PW'(BLANK_CYCLES));
    end
  endgenerate

  assign dark      = in_blank | blank_q[idx];
  assign anode_sel = ~(NUM_DIGITS'(1) << idx);

  // Scan counters and shadow registers. Reset wins over a coincident load,
  // so that load is discarded.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt    <= '0;
      idx     <= '0;
      // NOTE: the shadow registers are reset (blank_q to all ones) so the
      // display stays dark until the first explicit load.
      value_q <= '0;
      dp_q    <= '0;
      blank_q <= '1;
    end else begin
      if (load) begin
        value_q <= value;
        dp_q    <= dp_in;
        blank_q <= blank_in;
      end
      if (pcnt == PCNT_LAST) begin
        pcnt <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // Output stage: one register after (idx, pcnt, shadow), so slot_tick lines
  // up with the first dark cycle of each slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      anode     <= '1;
      cathode   <= SEG_OFF;
      dp        <= 1'b1;
      slot_tick <= 1'b0;
    end else begin
      slot_tick <= (pcnt == '0);
      if (dark) begin
        anode   <= '1;
        cathode <= SEG_OFF;
        dp      <= 1'b1;
      end else begin
        anode   <= anode_sel;
        cathode <= digit_seg;
        dp      <= ~dp_q[idx];
      end
    end
  end

endmodule
